cla_pipe_adder: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshakes. It splits a WIDTH-bit operation into NSEG = WIDTH/SEG segments. Each segment is summed by a SEG-bit lookahead group in its own pipeline stage, and the segment carry is registered into the next stage. It replaces the single-cycle 32-bit lookahead adder on wide datapaths in the threshold/square arithmetic chain, where a full-width combinational carry no longer meets timing.

---
 rtl/cla_pipe_adder.sv | 154 +++++++++++++++
 tb/tb_cla_pipe_adder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder/subtractor.
// A WIDTH-bit add is split into NSEG = WIDTH/SEG segments; stage k sums
// segment k with a SEG-bit lookahead group and registers the segment carry
// for stage k+1. One global stall (adv) freezes every stage at once.
module cla_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int NSEG = (SEG > 0) ? WIDTH / SEG : 1;

  // Reject geometries that cannot be cut into whole segments.
  generate
    if (SEG < 1) begin : g_bad_seg
      $error("cla_pipe_adder: SEG must be at least 1");
    end else if (WIDTH % SEG != 0) begin : g_bad_width
      $error("cla_pipe_adder: WIDTH must be a multiple of SEG");
    end
  endgenerate

  // SEG-bit lookahead group: every carry is a flat sum-of-products of the
  // generate/propagate terms and cin, so no carry ripples inside a segment.
  // Returns {carry_out, sum}.
  function automatic logic [SEG:0] cla_group(input logic [SEG-1:0] x,
                                             input logic [SEG-1:0] y,
                                             input logic           cin);
    logic [SEG-1:0] g;
    logic [SEG-1:0] p;
    logic [SEG:0]   c;
    logic           term;
    g = x & y;
    p = x ^ y;
    c = '0;
    c[0] = cin;
    for (int i = 0; i < SEG; i++) begin
      term = cin;
      for (int k = 0; k <= i; k++) term = term & p[k];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++) term = term & p[k];
        c[i+1] = c[i+1] | term;
      end
    end
    return {c[SEG], p ^ c[SEG-1:0]};
  endfunction

  logic w_adv;

  // The whole pipe moves only when the output slot is empty or being drained.
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  genvar gi;
  generate
    for (gi = 0; gi < NSEG; gi++) begin : g_stage
      // REM: operand bits still to be summed at this stage's input.
      // LOW: sum bits already produced by earlier stages.
      localparam int REM = WIDTH - gi * SEG;
      localparam int LOW = gi * SEG;

      logic [REM-1:0]     w_a;
      logic [REM-1:0]     w_b;
      logic               w_cin;
      logic               w_vin;
      logic [SEG:0]       w_grp;
      logic [LOW+SEG-1:0] w_sum_next;
      logic [LOW+SEG-1:0] r_sum;
      logic               r_valid;
      logic               r_carry;

      if (gi == 0) begin : g_first
        // Subtraction folds into the adder as a + ~b + 1; ci is ignored then.
        assign w_a        = a;
        assign w_b        = sub ? ~b : b;
        assign w_cin      = sub | ci;
        assign w_vin      = in_valid;
        assign w_grp      = cla_group(w_a[SEG-1:0], w_b[SEG-1:0], w_cin);
        assign w_sum_next = w_grp[SEG-1:0];
      end else begin : g_next
        assign w_a        = g_stage[gi-1].g_pipe.r_a;
        assign w_b        = g_stage[gi-1].g_pipe.r_b;
        assign w_cin      = g_stage[gi-1].r_carry;
        assign w_vin      = g_stage[gi-1].r_valid;
        assign w_grp      = cla_group(w_a[SEG-1:0], w_b[SEG-1:0], w_cin);
        assign w_sum_next = {w_grp[SEG-1:0], g_stage[gi-1].r_sum};
      end

      // Stage register: valid bit, accumulated low sum and this segment's carry.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_valid <= 1'b0;
          r_sum   <= '0;
          r_carry <= 1'b0;
        end else if (w_adv) begin
          r_valid <= w_vin;
          r_sum   <= w_sum_next;
          r_carry <= w_grp[SEG];
        end
      end

      if (gi < NSEG - 1) begin : g_pipe
        logic [REM-SEG-1:0] r_a;
        logic [REM-SEG-1:0] r_b;

        // Carry the not-yet-summed operand segments forward to later stages.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_a <= '0;
            r_b <= '0;
          end else if (w_adv) begin
            r_a <= w_a[REM-1:SEG];
            r_b <= w_b[REM-1:SEG];
          end
        end
      end else begin : g_last
        logic w_c_msb;
        logic r_ovf;

        // Carry into the MSB recovered from the MSB sum bit and its operands.
        assign w_c_msb = w_grp[SEG-1] ^ w_a[SEG-1] ^ w_b[SEG-1];

        // Signed overflow: carry into MSB differs from carry out of MSB.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_ovf <= 1'b0;
          end else if (w_adv) begin
            r_ovf <= w_c_msb ^ w_grp[SEG];
          end
        end

        assign out_valid = r_valid;
        assign s         = r_sum;
        assign co        = r_carry;
        assign ovf       = r_ovf;
      end
    end
  endgenerate

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: directed cases, bubbles,
// streaming with backpressure, asynchronous reset, and a parameter sweep.
module tb_cla_pipe_adder;

  typedef struct {
    logic [63:0] s;
    logic        co;
    logic        ovf;
    int          t;
  } exp_t;

  localparam int N_SWEEP  = 1000;
  localparam int N_STREAM = 100;

  logic clk;
  logic rst_n;
  logic sweep_go;
  int   n_checks;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on w-bit unsigned operands.
  function automatic exp_t ref_model(input int w, input logic [63:0] x, input logic [63:0] y,
                                     input logic cin, input logic sb);
    exp_t        r;
    logic [64:0] full;
    logic [63:0] mask;
    logic        sa, sy, ss;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    if (sb) begin
      full = {1'b0, x} - {1'b0, y};
      r.co = (x >= y);
    end else begin
      full = {1'b0, x} + {1'b0, y} + {64'd0, cin};
      r.co = full[w];
    end
    r.s   = full[63:0] & mask;
    sa    = x[w-1];
    sy    = y[w-1];
    ss    = r.s[w-1];
    r.ovf = sb ? ((sa != sy) && (ss != sa)) : ((sa == sy) && (ss != sa));
    r.t   = 0;
    return r;
  endfunction

  function automatic int sw_w(input int i);
    case (i)
      0: return 32;
      1: return 32;
      2: return 64;
      default: return 12;
    endcase
  endfunction

  function automatic int sw_s(input int i);
    case (i)
      0: return 32;
      1: return 4;
      2: return 16;
      default: return 3;
    endcase
  endfunction

  // ---------------- main DUT (32, 8) ----------------
  logic [31:0] m_a, m_b, m_s;
  logic        m_ci, m_sub, m_iv, m_ir, m_ov, m_ordy, m_co, m_ovf;

  cla_pipe_adder #(.WIDTH(32), .SEG(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(m_iv), .in_ready(m_ir),
    .a(m_a), .b(m_b), .ci(m_ci), .sub(m_sub),
    .out_valid(m_ov), .out_ready(m_ordy),
    .s(m_s), .co(m_co), .ovf(m_ovf)
  );

  // ---------------- parameter sweep instances ----------------
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sw
      localparam int W  = sw_w(gi);
      localparam int S  = sw_s(gi);
      localparam int NS = W / S;

      logic [W-1:0] t_a, t_b, t_s;
      logic         t_ci, t_sub, t_iv, t_ir, t_ov, t_co, t_ovf;
      logic         done;

      cla_pipe_adder #(.WIDTH(W), .SEG(S)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(t_iv), .in_ready(t_ir),
        .a(t_a), .b(t_b), .ci(t_ci), .sub(t_sub),
        .out_valid(t_ov), .out_ready(1'b1),
        .s(t_s), .co(t_co), .ovf(t_ovf)
      );

      initial begin
        exp_t        q[$];
        exp_t        e;
        logic [63:0] ra, rb;
        int          cyc, sent;
        done  = 1'b0;
        t_iv  = 1'b0;
        t_a   = '0;
        t_b   = '0;
        t_ci  = 1'b0;
        t_sub = 1'b0;
        wait (sweep_go);
        cyc  = 0;
        sent = 0;
        while ((sent < N_SWEEP || q.size() != 0) && cyc < N_SWEEP + 200) begin
          @(negedge clk);
          cyc++;
          if (t_ov) begin
            check_eq("sweep_extra", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
              e = q.pop_front();
              check_eq("sweep_s", 64'(t_s), e.s);
              check_eq("sweep_co", 64'(t_co), 64'(e.co));
              check_eq("sweep_ovf", 64'(t_ovf), 64'(e.ovf));
              check_eq("sweep_lat", 64'(cyc - e.t), 64'(NS));
              $display("sweep W=%0d S=%0d s=%h co=%b ovf=%b", W, S, t_s, t_co, t_ovf);
            end
          end
          check_eq("sweep_ready", 64'(t_ir), 64'd1);
          if (sent < N_SWEEP) begin
            ra    = {$urandom, $urandom};
            rb    = {$urandom, $urandom};
            t_a   = ra[W-1:0];
            t_b   = rb[W-1:0];
            t_ci  = 1'($urandom_range(0, 1));
            t_sub = 1'($urandom_range(0, 1));
            t_iv  = 1'b1;
            e     = ref_model(W, 64'(t_a), 64'(t_b), t_ci, t_sub);
            e.t   = cyc;
            q.push_back(e);
            sent++;
          end else begin
            t_iv = 1'b0;
          end
        end
        check_eq("sweep_drain", 64'(q.size()), 64'd0);
        done = 1'b1;
      end
    end
  endgenerate

  // Drive one op alone and check value and latency against fixed expectations.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic cin,
                        input logic sb, input logic [31:0] es, input logic eco,
                        input logic eovf);
    int lat;
    @(negedge clk);
    m_a = x; m_b = y; m_ci = cin; m_sub = sb; m_iv = 1'b1; m_ordy = 1'b1;
    @(negedge clk);
    m_iv = 1'b0;
    lat  = 1;
    while (!m_ov && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq("dir_lat", 64'(lat), 64'd4);
    check_eq("dir_s", 64'(m_s), 64'(es));
    check_eq("dir_co", 64'(m_co), 64'(eco));
    check_eq("dir_ovf", 64'(m_ovf), 64'(eovf));
    $display("dir a=%h b=%h ci=%b sub=%b -> s=%h co=%b ovf=%b lat=%0d",
             x, y, cin, sb, m_s, m_co, m_ovf, lat);
  endtask

  initial begin
    exp_t        mq[$];
    exp_t        e;
    logic [4:0]  pat;
    logic [34:0] prev_out;
    logic        stalled, have_op;
    int          sent, recv, cyc;

    n_checks = 0;
    n_fail   = 0;
    sweep_go = 1'b0;
    rst_n    = 1'b0;
    m_a = '0; m_b = '0; m_ci = 1'b0; m_sub = 1'b0; m_iv = 1'b0; m_ordy = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_ov", 64'(m_ov), 64'd0);
    check_eq("rst_out", 64'({m_s, m_co, m_ovf}), 64'd0);
    check_eq("rst_ready", 64'(m_ir), 64'd1);

    // Parameter sweep runs on its own instances.
    sweep_go = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      if (g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done) break;
      @(negedge clk);
    end
    check_eq("sweep_done",
             64'(g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done), 64'd1);

    // Directed cases.
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
    run_op(32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
    run_op(32'd10,       32'd3,        1'b1, 1'b1, 32'd7,        1'b1, 1'b0);

    // Bubbles: in_valid 1,0,1,1,0 reappears on out_valid four cycles later.
    @(negedge clk);
    pat    = 5'b01101;
    m_ordy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i > 0) check_eq("bubble_ov", 64'(m_ov), (i >= 4) ? 64'(pat[i-4]) : 64'd0);
      m_a  = $urandom;
      m_b  = $urandom;
      m_iv = (i < 5) ? pat[i] : 1'b0;
      $display("bubble cycle %0d in_valid=%b out_valid=%b", i, m_iv, m_ov);
    end

    // Streaming with random backpressure against an in-order scoreboard.
    sent = 0; recv = 0; cyc = 0; stalled = 1'b0; have_op = 1'b0; prev_out = '0;
    while (recv < N_STREAM && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (stalled) check_eq("stall_hold", 64'({m_ov, m_s, m_co, m_ovf}), 64'(prev_out));
      m_ordy = ($urandom_range(0, 3) != 0);
      if (!have_op && sent < N_STREAM) begin
        m_a = $urandom; m_b = $urandom;
        m_ci = 1'($urandom_range(0, 1)); m_sub = 1'($urandom_range(0, 1));
        have_op = 1'b1;
      end
      m_iv = have_op;
      #1;
      check_eq("stream_ready", 64'(m_ir), 64'(!m_ov || m_ordy));
      if (m_ov && m_ordy) begin
        check_eq("stream_extra", 64'(mq.size() != 0), 64'd1);
        if (mq.size() != 0) begin
          e = mq.pop_front();
          check_eq("stream_s", 64'(m_s), e.s);
          check_eq("stream_co", 64'(m_co), 64'(e.co));
          check_eq("stream_ovf", 64'(m_ovf), 64'(e.ovf));
          $display("stream #%0d s=%h co=%b ovf=%b", recv, m_s, m_co, m_ovf);
        end
        recv++;
      end
      stalled  = m_ov && !m_ordy;
      prev_out = {m_ov, m_s, m_co, m_ovf};
      if (m_iv && m_ir) begin
        mq.push_back(ref_model(32, 64'(m_a), 64'(m_b), m_ci, m_sub));
        sent++;
        have_op = 1'b0;
      end
    end
    m_iv = 1'b0;
    check_eq("stream_count", 64'(recv), 64'(N_STREAM));
    check_eq("stream_left", 64'(mq.size()), 64'd0);

    // Reset with three ops in flight and one at the output.
    @(negedge clk);
    m_ordy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      m_a = $urandom | 32'h1; m_b = $urandom; m_ci = 1'b0; m_sub = 1'b0; m_iv = 1'b1;
    end
    @(negedge clk);
    m_iv = 1'b0;
    check_eq("rst_pre_ov", 64'(m_ov), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_ov", 64'(m_ov), 64'd0);
    check_eq("arst_out", 64'({m_s, m_co, m_ovf}), 64'd0);
    $display("async reset out_valid=%b s=%h", m_ov, m_s);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("arst_ready", 64'(m_ir), 64'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("arst_stale", 64'(m_ov), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
